// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard, forwarding and data-memory wait controller
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic        ifid_uses_rs2,
   input  logic        idex_memread,
   input  logic [4:0]  idex_rd,
   input  logic [4:0]  idex_rs1,
   input  logic [4:0]  idex_rs2,
   input  logic        exmem_regwrite,
   input  logic        exmem_memread,
   input  logic        exmem_memwrite,
   input  logic [4:0]  exmem_rd,
   input  logic        memwb_regwrite,
   input  logic [4:0]  memwb_rd,
   input  logic        ex_redirect,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        dmem_req,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        mem_err,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] wait_q, wait_d;

   logic memop;
   logic loaduse;
   logic hazard_eval;
   logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
   logic ifid_flush_c, idex_flush_c, dmem_req_c;

   // EX/MEM result is newer than MEM/WB, so it wins when both match.
   always_comb begin
      fwd_a = 2'b00;
      if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rs1)) begin
         fwd_a = 2'b10;
      end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rs1)) begin
         fwd_a = 2'b01;
      end
   end

   always_comb begin
      fwd_b = 2'b00;
      if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rs2)) begin
         fwd_b = 2'b10;
      end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rs2)) begin
         fwd_b = 2'b01;
      end
   end

   assign memop   = exmem_memread | exmem_memwrite;
   assign loaduse = idex_memread & (idex_rd != 5'd0) &
                    ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & (idex_rd == ifid_rs2)));

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      hazard_eval  = 1'b0;
      dmem_req_c   = 1'b0;
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_en_c    = 1'b0;
      exmem_en_c   = 1'b0;
      memwb_en_c   = 1'b0;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;

      case (state_q)
         ST_RUN: begin
            dmem_req_c = memop;
            wait_d     = 16'd0;
            if (memop && !dmem_ready) begin
               state_d = ST_WAIT;
            end else begin
               hazard_eval = 1'b1;
            end
         end
         ST_WAIT: begin
            dmem_req_c = 1'b1;
            if (dmem_ready) begin
               hazard_eval = 1'b1;
               wait_d      = 16'd0;
               state_d     = ST_RUN;
            end else if (wait_q == WAIT_LAST) begin
               wait_d  = 16'd0;
               state_d = ST_ERR;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_ERR;
         end
      endcase

      // Redirect squashes the dependent instruction, so it outranks the load-use bubble.
      if (hazard_eval) begin
         if (ex_redirect) begin
            pc_en_c      = 1'b1;
            ifid_en_c    = 1'b1;
            idex_en_c    = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
         end else if (loaduse) begin
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
         end else begin
            pc_en_c    = 1'b1;
            ifid_en_c  = 1'b1;
            idex_en_c  = 1'b1;
            exmem_en_c = 1'b1;
            memwb_en_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         wait_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Control outputs are forced quiet for as long as reset is held.
   assign pc_en      = pc_en_c      & reset_n;
   assign ifid_en    = ifid_en_c    & reset_n;
   assign idex_en    = idex_en_c    & reset_n;
   assign exmem_en   = exmem_en_c   & reset_n;
   assign memwb_en   = memwb_en_c   & reset_n;
   assign ifid_flush = ifid_flush_c & reset_n;
   assign idex_flush = idex_flush_c & reset_n;
   assign dmem_req   = dmem_req_c   & reset_n;
   assign mem_err    = (state_q == ST_ERR);

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q, flush_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         if (!pc_en_c && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
         end
         if (ifid_flush_c && (flush_q != 32'hFFFF_FFFF)) begin
            flush_q <= flush_q + 32'd1;
         end
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_events = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning max MEM_WAIT cycles before error (range 2..65535).
REQ-002 SHALL use a single clock and asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-003 SHALL have reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have inputs ifid_rs1, ifid_rs2 (5 each) and ifid_uses_rs2 (1), the source registers decoded from the IF/ID instruction.
REQ-005 SHALL have inputs idex_memread (1), idex_rd, idex_rs1, idex_rs2 (5 each), taken from the ID/EX register.
REQ-006 SHALL have inputs exmem_regwrite, exmem_memread, exmem_memwrite (1 each) and exmem_rd (5), taken from the EX/MEM register.
REQ-007 SHALL have inputs memwb_regwrite (1) and memwb_rd (5), taken from the MEM/WB register.
REQ-008 SHALL have inputs ex_redirect (1, branch taken or jump/jalr in EX) and dmem_ready (1, data memory completes the access this cycle).
REQ-009 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en, memwb_en (1 each): the stage register loads when high and holds when low.
REQ-010 SHALL have outputs ifid_flush and idex_flush (1 each): the stage register loads a zero bubble.
REQ-011 SHALL have outputs dmem_req (1), fwd_a and fwd_b (2 each, 00 = register file, 01 = MEM/WB, 10 = EX/MEM), and mem_err (1).
REQ-012 SHALL have outputs stall_cycles and flush_events (32 each), the performance counters.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT and ERR.
REQ-014 SHALL drive fwd_a = 10 when exmem_regwrite, exmem_rd != 0 and exmem_rd == idex_rs1.
REQ-015 Otherwise, SHALL drive fwd_a = 01 when memwb_regwrite, memwb_rd != 0 and memwb_rd == idex_rs1; otherwise 00.
REQ-016 SHALL compute fwd_b identically to fwd_a using idex_rs2; fwd_a and fwd_b are combinational and valid in every state.
REQ-017 SHALL define memop = exmem_memread | exmem_memwrite.
REQ-018 In RUN, SHALL assert dmem_req = memop combinationally.
REQ-019 In RUN, when memop=1 and dmem_ready=0: all *_en = 0, no flush, next state MEM_WAIT.
REQ-020 In RUN, when memop=1 and dmem_ready=1: zero-wait access, with normal hazard handling this cycle.
REQ-021 SHALL define loaduse = idex_memread & (idex_rd != 0) & (idex_rd == ifid_rs1 | (ifid_uses_rs2 & idex_rd == ifid_rs2)).
REQ-022 In RUN with no memory stall and ex_redirect=1: pc_en=1, ifid_flush=1, idex_flush=1, and all other enables = 1.
REQ-023 ex_redirect SHALL take priority over loaduse.
REQ-024 In RUN with no memory stall, no redirect and loaduse=1: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1 (one bubble, one cycle).
REQ-025 In RUN with no memory stall, no redirect and no loaduse: all *_en = 1 and flushes = 0.
REQ-026 In MEM_WAIT, dmem_req SHALL be 1 and a wait counter SHALL increment each cycle.
REQ-027 In MEM_WAIT with dmem_ready=0: all *_en = 0 and flushes = 0; ex_redirect and loaduse are ignored (both remain held in the frozen registers).
REQ-028 In MEM_WAIT with dmem_ready=1: outputs follow the RUN rules for that cycle (redirect/loaduse evaluated), the counter clears and the next state is RUN.
REQ-029 When the wait counter reaches TIMEOUT_CYC-1 with dmem_ready still 0, SHALL enter ERR.
REQ-030 In ERR: all *_en = 0, flushes = 0, dmem_req = 0, mem_err = 1; SHALL leave ERR only on reset.
REQ-031 SHALL never assert a stage flush in the same cycle that the stage enable is 0, except idex_flush during loaduse.

Reset
REQ-032 While reset_n=0: state = RUN, wait counter = 0, counters = 0, mem_err = 0, all *_en = 0, flushes = 0, dmem_req = 0.
REQ-033 Reset asserted mid-MEM_WAIT SHALL immediately abort the wait; the first cycle after release SHALL follow the RUN rules.

Configuration
REQ-034 With HAZARD_PERF_CNT_EN defined: stall_cycles SHALL increment on every post-reset cycle with pc_en=0.
REQ-035 With HAZARD_PERF_CNT_EN defined: flush_events SHALL increment on every cycle with ifid_flush=1; both counters saturate at 32'hFFFFFFFF.
REQ-036 Without HAZARD_PERF_CNT_EN: both counter ports SHALL remain present and constant 0, with no counter flops.

Verification
REQ-037 idex_memread=1, idex_rd=5, ifid_rs1=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; the next cycle returns to all en=1.
REQ-038 exmem_regwrite=1, exmem_rd=3, memwb_regwrite=1, memwb_rd=3, idex_rs1=3 -> fwd_a=10; with exmem_rd=0 instead -> fwd_a=01.
REQ-039 exmem_memread=1, dmem_ready low for 3 cycles then high -> 3 frozen cycles, dmem_req=1 for 4 cycles, state returns to RUN; stall_cycles=3 when the macro is defined.
REQ-040 ex_redirect=1 together with loaduse=1 -> ifid_flush=1, idex_flush=1, pc_en=1; flush_events increments by 1.
REQ-041 TIMEOUT_CYC=4 with dmem_ready held 0 -> mem_err=1 after 4 wait cycles, all en=0; reset_n pulse -> mem_err=0, state RUN.
